// File: rtl/crypto1_core_sched.sv
// Crypto1 search-core job scheduler: sweeps 256 (even, odd) index pairs over NCORES slots,
// collects hits through a round-robin arbiter into a FWFT key FIFO. Option: CRYPTO1_SCHED_EARLY_STOP_EN.
module crypto1_core_sched #(
    parameter int NCORES     = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  CLK,
    input  logic                  RESETn,
    input  logic                  START,
    input  logic [47:0]           BITSTREAM,
    output logic                  BUSY,
    output logic                  DONE,
    output logic [8:0]            KEYS_FOUND,
    output logic [47:0]           CORE_BITSTREAM,
    output logic [NCORES-1:0]     CORE_START,
    output logic [4*NCORES-1:0]   CORE_EIDX,
    output logic [4*NCORES-1:0]   CORE_OIDX,
    input  logic [NCORES-1:0]     CORE_DONE,
    input  logic [NCORES-1:0]     CORE_HIT,
    input  logic [48*NCORES-1:0]  CORE_KEY,
    output logic                  KEY_VALID,
    output logic [47:0]           KEY_DATA,
    input  logic                  KEY_READY
);
    localparam int unsigned NC = NCORES;
    localparam int SW = (NCORES > 1) ? $clog2(NCORES) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DISPATCH, S_DRAIN, S_FINISH} state_t;
    typedef enum logic [1:0] {SLOT_FREE, SLOT_BUSY, SLOT_HELD} slot_t;

    state_t        state;
    slot_t         slot_st  [NCORES];
    logic [47:0]   slot_key [NCORES];
    logic [47:0]   bitstream_q;
    logic [8:0]    job;
    logic [SW-1:0] last_grant;

    logic [47:0]   fifo_mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic          fifo_empty, fifo_full, pop, push;

    logic          free_found, all_free, grant_found, dispatch_ok, stop_now;
    logic [SW-1:0] free_idx, grant_idx;
    int unsigned   idx;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop        = KEY_READY && !fifo_empty;
    assign KEY_VALID  = !fifo_empty;
    assign KEY_DATA   = fifo_empty ? '0 : fifo_mem[rd_ptr[AW-1:0]];

    // Full FIFO accepts a write only when the head is being consumed in the same cycle.
    assign push = grant_found && (!fifo_full || KEY_READY);

`ifdef CRYPTO1_SCHED_EARLY_STOP_EN
    assign stop_now = push;
`else
    assign stop_now = 1'b0;
`endif

    assign dispatch_ok = (state == S_DISPATCH) && !job[8] && free_found && !stop_now;

    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        all_free   = 1'b1;
        for (int unsigned i = NC; i > 0; i--) begin
            if (slot_st[i-1] == SLOT_FREE) begin
                free_found = 1'b1;
                free_idx   = SW'(i - 1);
            end else begin
                all_free = 1'b0;
            end
        end
    end

    // Search starts at the slot after the last one granted.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        for (int unsigned k = 1; k <= NC; k++) begin
            idx = (32'(last_grant) + k) % NC;
            if (!grant_found && slot_st[idx] == SLOT_HELD) begin
                grant_found = 1'b1;
                grant_idx   = SW'(idx);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (push) fifo_mem[wr_ptr[AW-1:0]] <= slot_key[grant_idx];
    end

    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            state          <= S_IDLE;
            BUSY           <= 1'b0;
            DONE           <= 1'b0;
            KEYS_FOUND     <= '0;
            CORE_BITSTREAM <= '0;
            CORE_START     <= '0;
            CORE_EIDX      <= '0;
            CORE_OIDX      <= '0;
            bitstream_q    <= '0;
            job            <= '0;
            last_grant     <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            for (int unsigned s = 0; s < NC; s++) begin
                slot_st[s]  <= SLOT_FREE;
                slot_key[s] <= '0;
            end
        end else begin
            CORE_START <= '0;
            DONE       <= 1'b0;

            for (int unsigned s = 0; s < NC; s++) begin
                case (slot_st[s])
                    SLOT_FREE: begin
                        if (dispatch_ok && free_idx == SW'(s)) begin
                            slot_st[s]           <= SLOT_BUSY;
                            CORE_START[s]        <= 1'b1;
                            CORE_EIDX[4*s +: 4]  <= job[7:4];
                            CORE_OIDX[4*s +: 4]  <= job[3:0];
                        end
                    end
                    SLOT_BUSY: begin
                        if (CORE_DONE[s]) begin
                            if (CORE_HIT[s]) begin
                                slot_st[s]  <= SLOT_HELD;
                                slot_key[s] <= CORE_KEY[48*s +: 48];
                            end else begin
                                slot_st[s] <= SLOT_FREE;
                            end
                        end
                    end
                    SLOT_HELD: begin
                        if (push && grant_idx == SW'(s)) slot_st[s] <= SLOT_FREE;
                    end
                    default: slot_st[s] <= SLOT_FREE;
                endcase
            end

            if (dispatch_ok) job <= job + 9'd1;

            if (push) begin
                wr_ptr     <= wr_ptr + 1'b1;
                last_grant <= grant_idx;
                if (KEYS_FOUND != 9'h1FF) KEYS_FOUND <= KEYS_FOUND + 9'd1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;

            case (state)
                S_IDLE: begin
                    if (START) begin
                        bitstream_q <= BITSTREAM;
                        job         <= '0;
                        KEYS_FOUND  <= '0;
                        BUSY        <= 1'b1;
                        state       <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    CORE_BITSTREAM <= bitstream_q;
                    state          <= S_DISPATCH;
                end
                S_DISPATCH: begin
                    if (stop_now || job[8]) state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (all_free) begin
                        DONE  <= 1'b1;
                        BUSY  <= 1'b0;
                        state <= S_FINISH;
                    end
                end
                S_FINISH: state <= S_IDLE;
                default:  state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_crypto1_core_sched.sv
// Directed bench for crypto1_core_sched with 3-cycle stub cores; honours CRYPTO1_SCHED_EARLY_STOP_EN.
module tb_crypto1_core_sched;
    localparam int NC = 4;

`ifdef CRYPTO1_SCHED_EARLY_STOP_EN
    localparam int BP_STALL_STARTS = 4;
    localparam int BP_KEYS         = 4;
    localparam bit BP_BUSY         = 1'b0;
    localparam bit ES              = 1'b1;
`else
    localparam int BP_STALL_STARTS = 8;
    localparam int BP_KEYS         = 10;
    localparam bit BP_BUSY         = 1'b1;
    localparam bit ES              = 1'b0;
`endif

    logic              CLK, RESETn, START, BUSY, DONE, KEY_VALID, KEY_READY;
    logic [47:0]       BITSTREAM, CORE_BITSTREAM, KEY_DATA;
    logic [8:0]        KEYS_FOUND;
    logic [NC-1:0]     CORE_START, CORE_DONE, CORE_HIT;
    logic [4*NC-1:0]   CORE_EIDX, CORE_OIDX;
    logic [48*NC-1:0]  CORE_KEY;

    logic              manual;
    logic [NC-1:0]     stub_done, stub_hit, man_done, man_hit;
    logic [48*NC-1:0]  stub_key, man_key;
    int                hit_lo, hit_hi;
    logic [47:0]       key_base;

    assign CORE_DONE = manual ? man_done : stub_done;
    assign CORE_HIT  = manual ? man_hit  : stub_hit;
    assign CORE_KEY  = manual ? man_key  : stub_key;

    crypto1_core_sched #(.NCORES(NC), .FIFO_DEPTH(4)) dut (
        .CLK(CLK), .RESETn(RESETn), .START(START), .BITSTREAM(BITSTREAM),
        .BUSY(BUSY), .DONE(DONE), .KEYS_FOUND(KEYS_FOUND), .CORE_BITSTREAM(CORE_BITSTREAM),
        .CORE_START(CORE_START), .CORE_EIDX(CORE_EIDX), .CORE_OIDX(CORE_OIDX),
        .CORE_DONE(CORE_DONE), .CORE_HIT(CORE_HIT), .CORE_KEY(CORE_KEY),
        .KEY_VALID(KEY_VALID), .KEY_DATA(KEY_DATA), .KEY_READY(KEY_READY)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Stub cores: CORE_DONE asserted 3 steps after the CORE_START strobe is seen.
    bit          pend [NC];
    int          cnt  [NC];
    logic [7:0]  sjob [NC];

    initial begin
        stub_done = '0; stub_hit = '0; stub_key = '0;
        for (int s = 0; s < NC; s++) begin pend[s] = 0; cnt[s] = 0; sjob[s] = '0; end
        forever begin
            @(posedge CLK); #2;
            for (int s = 0; s < NC; s++) begin
                stub_done[s] = 1'b0;
                stub_hit[s]  = 1'b0;
                if (manual) begin
                    if (!RESETn || man_done[s]) pend[s] = 0;
                end else if (pend[s]) begin
                    cnt[s] = cnt[s] - 1;
                    if (cnt[s] == 0) begin
                        pend[s]             = 0;
                        stub_done[s]        = 1'b1;
                        stub_hit[s]         = (int'(sjob[s]) >= hit_lo) && (int'(sjob[s]) <= hit_hi);
                        stub_key[48*s +: 48] = key_base ^ {40'b0, sjob[s]};
                    end
                end
                if (CORE_START[s]) begin
                    pend[s] = 1;
                    cnt[s]  = 3;
                    sjob[s] = {CORE_EIDX[4*s +: 4], CORE_OIDX[4*s +: 4]};
                end
            end
        end
    end

    // Observer: dispatch order, delivered keys, head stability.
    int          cyc, starts, exp_job, order_err, key_err, delivered, valid_cycles, late, first_job, stab_err;
    logic [255:0] seen;
    logic [47:0] del_key [256];
    int          del_job [256];
    int          del_cyc [256];
    logic        prev_valid, prev_ready;
    logic [47:0] prev_data, xk;
    logic [7:0]  jb;

    initial begin
        cyc = 0; starts = 0; exp_job = 0; order_err = 0; key_err = 0; delivered = 0;
        valid_cycles = 0; late = 0; first_job = -1; stab_err = 0; seen = '0;
        prev_valid = 1'b0; prev_ready = 1'b0; prev_data = '0;
        forever begin
            @(negedge CLK);
            cyc = cyc + 1;
            if (RESETn && START && !BUSY && !DONE) begin
                starts = 0; exp_job = 0; order_err = 0; key_err = 0; delivered = 0;
                valid_cycles = 0; late = 0; first_job = -1; seen = '0;
            end
            if (RESETn) begin
                if ($countones(CORE_START) > 1) order_err = order_err + 1;
                for (int s = 0; s < NC; s++) begin
                    if (CORE_START[s]) begin
                        jb = {CORE_EIDX[4*s +: 4], CORE_OIDX[4*s +: 4]};
                        if (first_job < 0) first_job = int'(jb);
                        if (int'(jb) != exp_job) order_err = order_err + 1;
                        exp_job = exp_job + 1;
                        starts  = starts + 1;
                        if (KEYS_FOUND != 9'd0) late = late + 1;
                    end
                end
                if (KEY_VALID) valid_cycles = valid_cycles + 1;
                if (prev_valid && !prev_ready && (!KEY_VALID || KEY_DATA != prev_data))
                    stab_err = stab_err + 1;
                if (KEY_VALID && KEY_READY) begin
                    xk = KEY_DATA ^ key_base;
                    jb = xk[7:0];
                    if (xk[47:8] != '0 || int'(jb) < hit_lo || int'(jb) > hit_hi || seen[jb])
                        key_err = key_err + 1;
                    seen[jb] = 1'b1;
                    if (delivered < 256) begin
                        del_key[delivered] = KEY_DATA;
                        del_job[delivered] = int'(jb);
                        del_cyc[delivered] = cyc;
                        delivered = delivered + 1;
                    end
                end
                prev_valid = KEY_VALID; prev_ready = KEY_READY; prev_data = KEY_DATA;
            end else begin
                prev_valid = 1'b0;
            end
        end
    end

    int n_cmp, n_fail;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK); #1;
    endtask

    task automatic do_start(input logic [47:0] bs);
        BITSTREAM = bs;
        START     = 1'b1;
        tick();
        START     = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit got, output logic [8:0] kf,
                             output logic [47:0] cbs, output logic busy_at);
        got = 0; kf = '0; cbs = '0; busy_at = 1'b1;
        for (int c = 0; c < budget; c++) begin
            tick();
            if (DONE) begin
                got = 1; kf = KEYS_FOUND; cbs = CORE_BITSTREAM; busy_at = BUSY;
                break;
            end
        end
    endtask

    task automatic drain_fifo(input int budget);
        for (int c = 0; c < budget && KEY_VALID; c++) tick();
    endtask

    task automatic reset_checks(input string p);
        check({p, "_busy"},  64'(BUSY), 64'(0));
        check({p, "_done"},  64'(DONE), 64'(0));
        check({p, "_kf"},    64'(KEYS_FOUND), 64'(0));
        check({p, "_start"}, 64'(CORE_START), 64'(0));
        check({p, "_eidx"},  64'(CORE_EIDX), 64'(0));
        check({p, "_oidx"},  64'(CORE_OIDX), 64'(0));
        check({p, "_cbs"},   64'(CORE_BITSTREAM), 64'(0));
        check({p, "_kvld"},  64'(KEY_VALID), 64'(0));
        check({p, "_kdat"},  64'(KEY_DATA), 64'(0));
    endtask

    typedef struct {
        logic [47:0] bs;
        int          lo;
        int          hi;
        logic [47:0] kbase;
        int          exp_keys;
        bit          exp_full;
        logic [47:0] exp_first;
    } vec_t;

    vec_t        vecs [4];
    bit          got;
    logic [8:0]  kf;
    logic [47:0] cbs;
    logic        busy_at;
    int          s0;

    initial begin
        vecs[0] = '{48'h0123456789AB, 1, 0, 48'h0, 0, 1'b1, 48'h0};
        vecs[1] = '{48'hFEDCBA987654, 8'h37, 8'h37, 48'hA0A1A2A3A492, 1, !ES, 48'hA0A1A2A3A4A5};
        vecs[2] = '{48'h5555AAAA5555, 20, 20, 48'h123456789A00, 1, !ES, 48'h123456789A14};
`ifdef CRYPTO1_SCHED_EARLY_STOP_EN
        vecs[3] = '{48'hC3C3C3C3C3C3, 8'hFF, 8'hFF, 48'hBEEF00000000, 1, 1'b1, 48'hBEEF000000FF};
`else
        vecs[3] = '{48'hC3C3C3C3C3C3, 8'hF0, 8'hFF, 48'hBEEF00000000, 16, 1'b1, 48'hBEEF000000F0};
`endif
        n_cmp = 0; n_fail = 0;
        RESETn = 1'b0; START = 1'b0; BITSTREAM = '0; KEY_READY = 1'b1;
        manual = 1'b0; man_done = '0; man_hit = '0; man_key = '0;
        hit_lo = 1; hit_hi = 0; key_base = '0;
        repeat (3) tick();
        reset_checks("por");
        RESETn = 1'b1;
        repeat (2) tick();

        for (int i = 0; i < 4; i++) begin
            hit_lo = vecs[i].lo; hit_hi = vecs[i].hi; key_base = vecs[i].kbase;
            KEY_READY = 1'b1;
            do_start(vecs[i].bs);
            wait_done(3000, got, kf, cbs, busy_at);
            check($sformatf("v%0d_done_seen", i), 64'(got), 64'(1));
            check($sformatf("v%0d_busy_at_done", i), 64'(busy_at), 64'(0));
            check($sformatf("v%0d_keys_found", i), 64'(kf), 64'(vecs[i].exp_keys));
            check($sformatf("v%0d_core_bs", i), 64'(cbs), 64'(vecs[i].bs));
            tick();
            check($sformatf("v%0d_done_pulse", i), 64'(DONE), 64'(0));
            drain_fifo(40);
            check($sformatf("v%0d_full_sweep", i), 64'(starts == 256), 64'(vecs[i].exp_full));
            check($sformatf("v%0d_order", i), 64'(order_err), 64'(0));
            check($sformatf("v%0d_key_err", i), 64'(key_err), 64'(0));
            check($sformatf("v%0d_delivered", i), 64'(delivered), 64'(vecs[i].exp_keys));
            if (vecs[i].exp_keys > 0) begin
                check($sformatf("v%0d_first_key", i), 64'(del_key[0]), 64'(vecs[i].exp_first));
`ifdef CRYPTO1_SCHED_EARLY_STOP_EN
                check($sformatf("v%0d_late_start", i), 64'(late), 64'(0));
`endif
            end else begin
                check($sformatf("v%0d_valid_cycles", i), 64'(valid_cycles), 64'(0));
            end
        end

        // Backpressure: consumer stalled while jobs 0..9 hit.
        hit_lo = 0; hit_hi = 9; key_base = 48'h5A5A00000000;
        KEY_READY = 1'b0;
        do_start(48'h111122223333);
        repeat (60) tick();
        check("bp_kf_full", 64'(KEYS_FOUND), 64'(4));
        check("bp_stall_starts", 64'(starts), 64'(BP_STALL_STARTS));
        check("bp_no_delivery", 64'(delivered), 64'(0));
        check("bp_head_valid", 64'(KEY_VALID), 64'(1));
        check("bp_head_data", 64'(KEY_DATA), 64'(48'h5A5A00000000));
        check("bp_busy", 64'(BUSY), 64'(BP_BUSY));
        KEY_READY = 1'b1;
`ifndef CRYPTO1_SCHED_EARLY_STOP_EN
        wait_done(3000, got, kf, cbs, busy_at);
        check("bp_done_seen", 64'(got), 64'(1));
`endif
        drain_fifo(60);
        check("bp_delivered", 64'(delivered), 64'(BP_KEYS));
        check("bp_kf_final", 64'(KEYS_FOUND), 64'(BP_KEYS));
        check("bp_key_err", 64'(key_err), 64'(0));
        check("bp_busy_end", 64'(BUSY), 64'(0));
        for (int i = 0; i < BP_KEYS; i++)
            check($sformatf("bp_order_%0d", i), 64'(del_job[i]), 64'(i));

        // Round-robin: two slots finish with hits in the same cycle.
        manual = 1'b1; hit_lo = 1; hit_hi = 0; key_base = '0;
        RESETn = 1'b0; tick(); RESETn = 1'b1; tick();
        do_start(48'h0);
        for (int c = 0; c < 30 && starts < 4; c++) tick();
        repeat (2) tick();
        check("rr_starts4", 64'(starts), 64'(4));
        man_key = '0;
        man_key[48*1 +: 48] = 48'h111111111111;
        man_key[48*2 +: 48] = 48'h222222222222;
        man_done = 4'b0110; man_hit = 4'b0110;
        tick();
        man_done = '0; man_hit = '0;
        repeat (6) tick();
        check("rr1_count", 64'(delivered), 64'(2));
        check("rr1_first", 64'(del_key[0]), 64'(48'h111111111111));
        check("rr1_second", 64'(del_key[1]), 64'(48'h222222222222));
        check("rr1_consec", 64'(del_cyc[1] - del_cyc[0]), 64'(1));
        for (int c = 0; c < 30 && starts < 6; c++) tick();
        repeat (2) tick();
        man_key[48*1 +: 48] = 48'h444444444444;
        man_key[48*3 +: 48] = 48'h333333333333;
        man_done = 4'b1010; man_hit = 4'b1010;
        tick();
        man_done = '0; man_hit = '0;
        repeat (6) tick();
        check("rr2_count", 64'(delivered), 64'(4));
        check("rr2_first", 64'(del_key[2]), 64'(48'h333333333333));
        check("rr2_second", 64'(del_key[3]), 64'(48'h444444444444));
        check("rr2_consec", 64'(del_cyc[3] - del_cyc[2]), 64'(1));
        check("rr2_kf", 64'(KEYS_FOUND), 64'(4));
        RESETn = 1'b0; tick(); RESETn = 1'b1;
        manual = 1'b0; man_key = '0;
        repeat (2) tick();

        // Reset in the middle of a sweep, with stale CORE_DONE pulses following.
        hit_lo = 1; hit_hi = 0; key_base = '0;
        do_start(48'hDEADBEEFCAFE);
        for (int c = 0; c < 600 && starts < 100; c++) tick();
        check("mid_reached_100", 64'(starts >= 100), 64'(1));
        RESETn = 1'b0;
        tick();
        reset_checks("mid");
        RESETn = 1'b1;
        s0 = starts;
        repeat (8) tick();
        check("stale_no_dispatch", 64'(starts), 64'(s0));
        check("stale_busy", 64'(BUSY), 64'(0));
        check("stale_kvld", 64'(KEY_VALID), 64'(0));
        do_start(48'h0123456789AB);
        wait_done(3000, got, kf, cbs, busy_at);
        check("restart_done", 64'(got), 64'(1));
        check("restart_first_job", 64'(first_job), 64'(0));
        check("restart_starts", 64'(starts), 64'(256));
        check("restart_order", 64'(order_err), 64'(0));
        check("restart_kf", 64'(kf), 64'(0));
        check("head_stability", 64'(stab_err), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
